// File: rtl/icache_fetch_linebuf.sv
// icache_fetch_linebuf
// Fetch-side instruction-cache front end. Holds NUM_LINES fully-associative
// line buffers that serve hits combinationally. Misses go through a
// request/response FSM (IDLE -> REQ -> WAIT -> IDLE, with DRAIN after a flush
// that leaves a response in flight). TLB-miss replay, page faults,
// misaligned fetches and flush/kill are handled here.
//
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   fetch_valid_i, fetch_vaddr_i    fetch request
//   flush_i                         invalidate buffers, abort outstanding miss
//   icache_req_*                    line request to ICache (valid/ready/idx/kill)
//   tlb_req_valid_o, tlb_req_vpn_o  TLB lookup request
//   icache_resp_*                   line response (valid/data/ready)
//   tlb_resp_miss_i, tlb_resp_xcpt_i TLB replay / page-fault flags
//   fetch_valid_o, fetch_data_o     instruction word back to fetch
//   fetch_ex_*                      exception valid/cause/origin
module icache_fetch_linebuf #(
  parameter int LINE_W    = 128,
  parameter int INST_W    = 32,
  parameter int ADDR_W    = 40,
  parameter int NUM_LINES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_valid_i,
  input  logic [ADDR_W-1:0]   fetch_vaddr_i,
  input  logic                flush_i,
  output logic                icache_req_valid_o,
  input  logic                icache_req_ready_i,
  output logic [11:0]         icache_req_idx_o,
  output logic                icache_req_kill_o,
  output logic                tlb_req_valid_o,
  output logic [ADDR_W-13:0]  tlb_req_vpn_o,
  input  logic                icache_resp_valid_i,
  input  logic [LINE_W-1:0]   icache_resp_data_i,
  output logic                icache_resp_ready_o,
  input  logic                tlb_resp_miss_i,
  input  logic                tlb_resp_xcpt_i,
  output logic                fetch_valid_o,
  output logic [INST_W-1:0]   fetch_data_o,
  output logic                fetch_ex_valid_o,
  output logic [1:0]          fetch_ex_cause_o,
  output logic [ADDR_W-1:0]   fetch_ex_origin_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IOFF_W = $clog2(INST_W / 8);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int RR_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [LINE_W-1:0]      data_q [NUM_LINES];
  logic [RR_W-1:0]        rr_q, rr_d;
  logic [TAG_W-1:0]       miss_tag_q, miss_tag_d;

  logic [TAG_W-1:0]       tag_s;
  logic                   misalign_s;
  logic [NUM_LINES-1:0]   hit_vec_s;
  logic                   hit_s;
  logic [LINE_W-1:0]      hit_line_s;
  logic                   fill_en_s;
  logic [RR_W-1:0]        fill_idx_s;

  logic                   fv_s, ex_s, req_valid_s, kill_s, resp_ready_s;
  logic [1:0]             cause_s;
  logic [INST_W-1:0]      data_s;

  // Instruction word addressed by the line offset of va within a line.
  function automatic logic [INST_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [ADDR_W-1:0] va);
    logic [OFF_W-1:0] off;
    off = va[OFF_W-1:0];
    return INST_W'(line >> (INST_W * int'(off >> IOFF_W)));
  endfunction

  assign tag_s      = fetch_vaddr_i[ADDR_W-1:OFF_W];
  assign misalign_s = fetch_valid_i && (fetch_vaddr_i[IOFF_W-1:0] != '0);
  assign hit_s      = |hit_vec_s;

  // Tag match against every valid entry; the hit line is muxed out.
  always_comb begin
    hit_line_s = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      hit_vec_s[i] = valid_q[i] && (tag_q[i] == tag_s);
      if (hit_vec_s[i]) begin
        hit_line_s = data_q[i];
      end else begin
        hit_line_s = hit_line_s;
      end
    end
  end

  // A good response fills only if no flush, fault or TLB replay accompanies it.
  assign fill_en_s = (state_q == S_WAIT) && icache_resp_valid_i && !flush_i &&
                     !tlb_resp_xcpt_i && !tlb_resp_miss_i;

  // Victim choice: lowest invalid entry, otherwise the round-robin pointer.
  always_comb begin
    fill_idx_s = rr_q;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        fill_idx_s = RR_W'(i);
      end else begin
        fill_idx_s = fill_idx_s;
      end
    end
  end

  // Valid bits and round-robin pointer next state; flush wins over fill.
  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (fill_en_s) begin
      valid_d[fill_idx_s] = 1'b1;
      if (&valid_q) begin
        rr_d = (rr_q == RR_W'(NUM_LINES - 1)) ? '0 : rr_q + RR_W'(1);
      end else begin
        rr_d = rr_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // FSM state register plus valid/rr/miss-tag bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      rr_q       <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Line storage needs no reset; the valid bits gate its use.
  always_ff @(posedge clk_i) begin
    if (fill_en_s) begin
      tag_q[fill_idx_s]  <= miss_tag_q;
      data_q[fill_idx_s] <= icache_resp_data_i;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    case (state_q)
      S_IDLE: begin
        if (!flush_i && fetch_valid_i && !misalign_s && !hit_s) begin
          state_d    = S_REQ;
          miss_tag_d = tag_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (icache_req_ready_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (icache_resp_valid_i) begin
          // Fault beats replay; a flush discards the response outright.
          if (!flush_i && !tlb_resp_xcpt_i && tlb_resp_miss_i) begin
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (icache_resp_valid_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    fv_s         = 1'b0;
    ex_s         = 1'b0;
    cause_s      = 2'd0;
    data_s       = '0;
    req_valid_s  = 1'b0;
    kill_s       = 1'b0;
    resp_ready_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (misalign_s) begin
          fv_s    = 1'b1;
          ex_s    = 1'b1;
          cause_s = 2'd1;
        end else if (fetch_valid_i && hit_s && !flush_i) begin
          fv_s   = 1'b1;
          data_s = word_sel(hit_line_s, fetch_vaddr_i);
        end else begin
          fv_s = 1'b0;
        end
      end
      S_REQ: begin
        req_valid_s = !flush_i;
      end
      S_WAIT: begin
        resp_ready_s = 1'b1;
        if (icache_resp_valid_i && !flush_i) begin
          if (tlb_resp_xcpt_i) begin
            fv_s    = 1'b1;
            ex_s    = 1'b1;
            cause_s = 2'd2;
          end else if (!tlb_resp_miss_i && (tag_s == miss_tag_q)) begin
            // Bypass only when fetch is still asking for the missed line.
            fv_s   = 1'b1;
            data_s = word_sel(icache_resp_data_i, fetch_vaddr_i);
          end else begin
            fv_s = 1'b0;
          end
        end else if (flush_i && !icache_resp_valid_i) begin
          kill_s = 1'b1;
        end else begin
          kill_s = 1'b0;
        end
      end
      S_DRAIN: begin
        resp_ready_s = 1'b1;
      end
      default: begin
        fv_s = 1'b0;
      end
    endcase
  end

  // Reset forces every output low, including the address pass-throughs.
  assign fetch_valid_o       = fv_s & ~rst_i;
  assign fetch_data_o        = rst_i ? '0 : data_s;
  assign fetch_ex_valid_o    = ex_s & ~rst_i;
  assign fetch_ex_cause_o    = rst_i ? 2'd0 : cause_s;
  assign fetch_ex_origin_o   = rst_i ? '0 : fetch_vaddr_i;
  assign icache_req_valid_o  = req_valid_s & ~rst_i;
  assign tlb_req_valid_o     = req_valid_s & ~rst_i;
  assign icache_req_kill_o   = kill_s & ~rst_i;
  assign icache_resp_ready_o = resp_ready_s & ~rst_i;
  assign icache_req_idx_o    = rst_i ? 12'd0 : {fetch_vaddr_i[11:OFF_W], {OFF_W{1'b0}}};
  assign tlb_req_vpn_o       = rst_i ? '0 : fetch_vaddr_i[ADDR_W-1:12];

endmodule

// File: tb/tb_icache_fetch_linebuf.sv
// Testbench for icache_fetch_linebuf: directed scenarios followed by random
// fetches, checked against a transaction-level model of the line buffers.
module tb_icache_fetch_linebuf;

  localparam int LINE_W    = 128;
  localparam int INST_W    = 32;
  localparam int ADDR_W    = 40;
  localparam int NUM_LINES = 2;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               fetch_valid_i;
  logic [ADDR_W-1:0]  fetch_vaddr_i;
  logic               flush_i;
  logic               icache_req_valid_o;
  logic               icache_req_ready_i;
  logic [11:0]        icache_req_idx_o;
  logic               icache_req_kill_o;
  logic               tlb_req_valid_o;
  logic [ADDR_W-13:0] tlb_req_vpn_o;
  logic               icache_resp_valid_i;
  logic [LINE_W-1:0]  icache_resp_data_i;
  logic               icache_resp_ready_o;
  logic               tlb_resp_miss_i;
  logic               tlb_resp_xcpt_i;
  logic               fetch_valid_o;
  logic [INST_W-1:0]  fetch_data_o;
  logic               fetch_ex_valid_o;
  logic [1:0]         fetch_ex_cause_o;
  logic [ADDR_W-1:0]  fetch_ex_origin_o;

  icache_fetch_linebuf #(
    .LINE_W(LINE_W), .INST_W(INST_W), .ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_vaddr_i(fetch_vaddr_i), .flush_i(flush_i),
    .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
    .icache_req_idx_o(icache_req_idx_o), .icache_req_kill_o(icache_req_kill_o),
    .tlb_req_valid_o(tlb_req_valid_o), .tlb_req_vpn_o(tlb_req_vpn_o),
    .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(icache_resp_data_i),
    .icache_resp_ready_o(icache_resp_ready_o),
    .tlb_resp_miss_i(tlb_resp_miss_i), .tlb_resp_xcpt_i(tlb_resp_xcpt_i),
    .fetch_valid_o(fetch_valid_o), .fetch_data_o(fetch_data_o),
    .fetch_ex_valid_o(fetch_ex_valid_o), .fetch_ex_cause_o(fetch_ex_cause_o),
    .fetch_ex_origin_o(fetch_ex_origin_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffer contents and round-robin pointer.
  logic               m_valid [NUM_LINES];
  logic [35:0]        m_tag   [NUM_LINES];
  logic [LINE_W-1:0]  m_data  [NUM_LINES];
  int                 m_rr;
  logic [ADDR_W-1:0]  pool    [5];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic m_flush();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
  endtask

  function automatic int m_find(input logic [ADDR_W-1:0] va);
    for (int i = 0; i < NUM_LINES; i++)
      if (m_valid[i] && m_tag[i] == va[39:4]) return i;
    return -1;
  endfunction

  task automatic m_fill(input logic [ADDR_W-1:0] va, input logic [LINE_W-1:0] d);
    int e;
    e = -1;
    for (int i = NUM_LINES - 1; i >= 0; i--) if (!m_valid[i]) e = i;
    if (e < 0) begin
      e = m_rr;
      m_rr = (m_rr + 1) % NUM_LINES;
    end
    m_valid[e] = 1'b1;
    m_tag[e]   = va[39:4];
    m_data[e]  = d;
  endtask

  function automatic logic [INST_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                input logic [ADDR_W-1:0] va);
    return INST_W'(line >> (32 * int'(va[3:2])));
  endfunction

  // One miss transaction; fetch holds va throughout.
  // kind: 0 good, 1 one TLB replay then good, 2 page fault
  // fl:   0 none, 1 flush in REQ, 2 flush in WAIT (stale resp later), 3 flush with resp
  task automatic run_miss(input logic [ADDR_W-1:0] va, input logic [LINE_W-1:0] line,
                          input int stall, input int lat, input int kind, input int fl,
                          input bit chg);
    int passes;
    passes = (kind == 1) ? 2 : 1;
    fetch_valid_i = 1'b1;
    fetch_vaddr_i = va;
    #4;
    chk("miss_idle_fv", fetch_valid_o, 1'b0);
    chk("miss_idle_req", icache_req_valid_o, 1'b0);
    step();
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s <= stall; s++) begin
        if (fl == 1 && p == passes - 1 && s == stall) begin
          flush_i = 1'b1;
          icache_req_ready_i = 1'b1;
          #4;
          chk("req_flush_valid", icache_req_valid_o, 1'b0);
          chk("req_flush_fv", fetch_valid_o, 1'b0);
          step();
          m_flush();
          flush_i = 1'b0;
          icache_req_ready_i = 1'b0;
          fetch_valid_i = 1'b0;
          #4;
          chk("req_flush_idle", icache_resp_ready_o, 1'b0);
          chk("req_flush_noreq", icache_req_valid_o, 1'b0);
          step();
          return;
        end
        icache_req_ready_i = (s == stall);
        #4;
        chk("req_valid", icache_req_valid_o, 1'b1);
        chk("tlb_valid", tlb_req_valid_o, 1'b1);
        chk("req_idx", icache_req_idx_o, {va[11:4], 4'h0});
        chk("tlb_vpn", tlb_req_vpn_o, va[39:12]);
        chk("req_fv", fetch_valid_o, 1'b0);
        step();
      end
      icache_req_ready_i = 1'b0;
      for (int w = 0; w < lat; w++) begin
        #4;
        chk("wait_ready", icache_resp_ready_o, 1'b1);
        chk("wait_fv", fetch_valid_o, 1'b0);
        chk("wait_noreq", icache_req_valid_o, 1'b0);
        step();
      end
      if (fl == 2 && p == passes - 1) begin
        flush_i = 1'b1;
        #4;
        chk("kill_pulse", icache_req_kill_o, 1'b1);
        chk("kill_fv", fetch_valid_o, 1'b0);
        step();
        flush_i = 1'b0;
        m_flush();
        repeat (2) begin
          #4;
          chk("drain_nokill", icache_req_kill_o, 1'b0);
          chk("drain_ready", icache_resp_ready_o, 1'b1);
          chk("drain_fv", fetch_valid_o, 1'b0);
          step();
        end
        icache_resp_valid_i = 1'b1;
        icache_resp_data_i  = line;
        #4;
        chk("stale_fv", fetch_valid_o, 1'b0);
        step();
        icache_resp_valid_i = 1'b0;
        fetch_valid_i = 1'b0;
        #4;
        chk("post_drain_idle", icache_resp_ready_o, 1'b0);
        step();
        return;
      end
      icache_resp_valid_i = 1'b1;
      icache_resp_data_i  = line;
      tlb_resp_miss_i     = (kind == 1 && p == 0);
      tlb_resp_xcpt_i     = (kind == 2);
      flush_i             = (fl == 3 && p == passes - 1);
      if (chg) fetch_vaddr_i = va ^ 40'h10_0000;
      #4;
      if (flush_i) begin
        chk("flresp_fv", fetch_valid_o, 1'b0);
        chk("flresp_kill", icache_req_kill_o, 1'b0);
      end else if (kind == 2) begin
        chk("xcpt_fv", fetch_valid_o, 1'b1);
        chk("xcpt_ex", fetch_ex_valid_o, 1'b1);
        chk("xcpt_cause", fetch_ex_cause_o, 2'd2);
        chk("xcpt_origin", fetch_ex_origin_o, va);
      end else if (tlb_resp_miss_i) begin
        chk("tlbmiss_fv", fetch_valid_o, 1'b0);
      end else if (chg) begin
        chk("chg_fv", fetch_valid_o, 1'b0);
      end else begin
        chk("bypass_fv", fetch_valid_o, 1'b1);
        chk("bypass_ex", fetch_ex_valid_o, 1'b0);
        chk("bypass_data", fetch_data_o, word_of(line, va));
      end
      step();
      if (flush_i) m_flush();
      else if (kind == 0 || (kind == 1 && p == 1)) m_fill(va, line);
      icache_resp_valid_i = 1'b0;
      tlb_resp_miss_i = 1'b0;
      tlb_resp_xcpt_i = 1'b0;
      flush_i = 1'b0;
      fetch_vaddr_i = va;
      if (fl == 3 && p == passes - 1) begin
        fetch_valid_i = 1'b0;
        #4;
        chk("flresp_idle", icache_resp_ready_o, 1'b0);
        step();
      end
    end
    fetch_valid_i = 1'b0;
  endtask

  // One fetch from IDLE, resolved against the model (misaligned, hit or miss).
  task automatic do_fetch(input logic [ADDR_W-1:0] va, input bit rnd);
    int e;
    bit fl;
    int kind, mfl, r;
    e  = m_find(va);
    fl = rnd && ($urandom_range(0, 15) == 0);
    if (va[1:0] != 2'b00) begin
      fetch_valid_i = 1'b1;
      fetch_vaddr_i = va;
      flush_i = fl;
      #4;
      chk("mis_fv", fetch_valid_o, 1'b1);
      chk("mis_ex", fetch_ex_valid_o, 1'b1);
      chk("mis_cause", fetch_ex_cause_o, 2'd1);
      chk("mis_origin", fetch_ex_origin_o, va);
      chk("mis_noreq", icache_req_valid_o, 1'b0);
      step();
      if (fl) m_flush();
      fetch_valid_i = 1'b0;
      flush_i = 1'b0;
    end else if (e >= 0) begin
      fetch_valid_i = 1'b1;
      fetch_vaddr_i = va;
      flush_i = fl;
      #4;
      chk("hit_fv", fetch_valid_o, !fl);
      if (!fl) chk("hit_data", fetch_data_o, word_of(m_data[e], va));
      chk("hit_ex", fetch_ex_valid_o, 1'b0);
      chk("hit_noreq", icache_req_valid_o, 1'b0);
      step();
      if (fl) m_flush();
      fetch_valid_i = 1'b0;
      flush_i = 1'b0;
      #4;
      chk("hit_stay_idle", icache_req_valid_o, 1'b0);
      step();
    end else begin
      r = $urandom_range(0, 9);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      r = $urandom_range(0, 11);
      mfl = (r < 3) ? r + 1 : 0;
      run_miss(va, {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 2), $urandom_range(0, 2), kind, mfl,
               (kind == 0 && mfl == 0 && $urandom_range(0, 7) == 0));
    end
  endtask

  localparam logic [LINE_W-1:0] LINE_A = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};

  initial begin
    logic [ADDR_W-1:0] va;
    int off;
    rst_i = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_vaddr_i = 40'h1002;
    flush_i = 1'b0;
    icache_req_ready_i = 1'b0;
    icache_resp_valid_i = 1'b0;
    icache_resp_data_i = '0;
    tlb_resp_miss_i = 1'b0;
    tlb_resp_xcpt_i = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) pool[i] = {8'(i * 37 + 1), 20'($urandom), 8'($urandom), 4'h0};
    #2;
    chk("rst_fv", fetch_valid_o, 1'b0);
    chk("rst_ex", fetch_ex_valid_o, 1'b0);
    chk("rst_origin", fetch_ex_origin_o, 40'h0);
    chk("rst_idx", icache_req_idx_o, 12'h0);
    chk("rst_req", icache_req_valid_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    fetch_valid_i = 1'b0;
    #4;
    chk("post_rst_req", icache_req_valid_o, 1'b0);
    chk("post_rst_ready", icache_resp_ready_o, 1'b0);
    step();

    // Single fetch then 0-latency hit on the same line.
    run_miss(40'h1000, LINE_A, 1, 0, 0, 0, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_vaddr_i = 40'h100C;
    #4;
    chk("hit_d3", fetch_data_o, 32'hDDDD_0003);
    step();
    fetch_valid_i = 1'b0;
    do_fetch(40'h1002, 1'b0);

    // Replacement: 0x3000 evicts entry 0, so 0x2000 stays and 0x1000 is gone.
    run_miss(40'h2000, ~LINE_A, 0, 0, 0, 0, 1'b0);
    run_miss(40'h3000, LINE_A ^ 128'h5, 0, 1, 0, 0, 1'b0);
    do_fetch(40'h2004, 1'b0);
    run_miss(40'h1000, LINE_A, 0, 0, 0, 0, 1'b0);

    // TLB replay and page fault; faulted line must still miss afterwards.
    run_miss(40'h4000, {4{32'h4444_0000}}, 0, 0, 1, 0, 1'b0);
    run_miss(40'h5000, {4{32'h5555_0000}}, 0, 0, 2, 0, 1'b0);
    run_miss(40'h5000, {4{32'h5555_1111}}, 0, 0, 0, 0, 1'b0);

    // Flush in WAIT with stale response, then 0x1000 misses again.
    run_miss(40'h6000, {4{32'h6666_0000}}, 0, 1, 0, 2, 1'b0);
    run_miss(40'h1000, LINE_A, 0, 0, 0, 0, 1'b0);
    run_miss(40'h7000, {4{32'h7777_0000}}, 0, 0, 0, 3, 1'b0);
    run_miss(40'h8000, {4{32'h8888_0000}}, 0, 0, 0, 1, 1'b0);

    // Reset asserted while REQ is pending.
    fetch_valid_i = 1'b1;
    fetch_vaddr_i = 40'h9000;
    #4;
    chk("rreq_idle_fv", fetch_valid_o, 1'b0);
    step();
    #4;
    chk("rreq_req", icache_req_valid_o, 1'b1);
    #1;
    rst_i = 1'b1;
    #1;
    chk("rreq_async_req", icache_req_valid_o, 1'b0);
    chk("rreq_async_tlb", tlb_req_valid_o, 1'b0);
    chk("rreq_async_kill", icache_req_kill_o, 1'b0);
    m_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    fetch_valid_i = 1'b0;
    #4;
    chk("rreq_after", icache_req_valid_o, 1'b0);
    step();

    // Random traffic over a small pool of lines.
    for (int n = 0; n < 300; n++) begin
      off = $urandom_range(0, 15);
      if ($urandom_range(0, 7) != 0) off = off & 12;
      va = pool[$urandom_range(0, 4)] | 40'(off);
      do_fetch(va, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetch_linebuf.md
# icache_fetch_linebuf

Parametrised fetch-side instruction-cache interface, placed between the fetch stage and the ICache/TLB request ports. It holds NUM_LINES fully-associative line buffers instead of a single line, and serves hits combinationally. Misses run through a request/response FSM with a ready handshake. The block also handles TLB-miss replay, page-fault and misalignment exceptions, and flush/kill with response draining.

## Interface
- LINE_W, 128: cache line width in bits; power of two, ≥ INST_W.
- INST_W, 32: instruction word width; power of two, ≥ 16.
- ADDR_W, 40: virtual address width; > 12.
- NUM_LINES, 2: number of line buffer entries, ≥ 1.
- Derived: OFF_W = log2(LINE_W/8); IOFF_W = log2(INST_W/8); TAG = vaddr[ADDR_W-1:OFF_W].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- fetch_valid_i  in  1  fetch request valid
- fetch_vaddr_i  in  ADDR_W  fetch virtual address
- flush_i  in  1  invalidate all buffers and abort any outstanding miss
- icache_req_valid_o  out  1  line request to ICache
- icache_req_ready_i  in  1  ICache accepts request
- icache_req_idx_o  out  12  fetch_vaddr_i[11:0] with bits [OFF_W-1:0] zeroed
- icache_req_kill_o  out  1  kill pulse for the outstanding request
- tlb_req_valid_o  out  1  equals icache_req_valid_o
- tlb_req_vpn_o  out  ADDR_W-12  fetch_vaddr_i[ADDR_W-1:12]
- icache_resp_valid_i  in  1  response valid
- icache_resp_data_i  in  LINE_W  response line
- icache_resp_ready_o  out  1  high in WAIT and DRAIN
- tlb_resp_miss_i  in  1  TLB miss; replay the request
- tlb_resp_xcpt_i  in  1  instruction page fault
- fetch_valid_o  out  1  response to fetch valid
- fetch_data_o  out  INST_W  selected instruction word
- fetch_ex_valid_o  out  1  exception present
- fetch_ex_cause_o  out  2  0 none, 1 misaligned, 2 fault fetch
- fetch_ex_origin_o  out  ADDR_W  fetch_vaddr_i

## Operation
- **Storage:** per entry there is a valid bit, a TAG and LINE_W of data. There is also a round-robin pointer rr of width max(1, log2 NUM_LINES).
- **Word select:** fetch_data_o = line[INST_W*w +: INST_W], where w = vaddr[OFF_W-1:IOFF_W].
- **Misaligned:** fetch_valid_i with vaddr[IOFF_W-1:0] ≠ 0 gives fetch_valid_o=1, ex_valid=1, cause=1. No request is issued. This check has priority over hit and miss.
- **Hit:** in IDLE, fetch_valid_i and a valid entry's tag equals TAG give fetch_valid_o=1, ex=0, with data from that entry.
- **Miss, IDLE→REQ:** fetch_valid_i, aligned, and no hit. The FSM moves to REQ with no output.
- **REQ:** icache_req_valid_o = tlb_req_valid_o = 1, held until icache_req_ready_i, then → WAIT.
- **WAIT:** icache_resp_ready_o=1.
  - On icache_resp_valid_i with no TLB flag: fill the lowest-index invalid entry, or entry rr if all are valid. rr advances only when the fill replaces a valid entry, wrapping NUM_LINES-1→0. The tag written is the miss tag latched at IDLE→REQ.
  - fetch_valid_o=1 in the same cycle, with data bypassed from icache_resp_data_i, only if the current TAG equals the miss tag. Then → IDLE.
  - tlb_resp_miss_i with resp_valid: no fill, → REQ (replay).
  - tlb_resp_xcpt_i with resp_valid: no fill; fetch_valid_o=1, ex_valid=1, cause=2; → IDLE. xcpt has priority over miss.
- **Flush:** all valid bits clear at the next edge; rr is unchanged. The FSM responds by state:
  - In IDLE: no further effect.
  - In REQ: → IDLE; request dropped even if ready is high that cycle.
  - In WAIT without resp_valid: icache_req_kill_o=1 for that one cycle, → DRAIN.
  - In WAIT with resp_valid: response consumed and discarded, → IDLE.
- **DRAIN:** icache_resp_ready_o=1. The next icache_resp_valid_i is discarded, → IDLE. fetch_valid_o=0 throughout.
- **Outputs:** fetch_valid_o=0 in REQ and in DRAIN, and in WAIT except on the same-cycle bypass. During a flush cycle fetch_valid_o=0, except for a misaligned exception.
- **Reset:** every output is 0 and every entry invalid; state IDLE, rr=0. Reset mid-miss abandons the request with no kill pulse.

## Timing
- Hit and misalignment have 0-cycle latency; outputs are combinational from fetch inputs and buffer state.
- Miss: IDLE→REQ takes 1 cycle, and REQ holds for ≥1 cycle until ready. The earliest response is one cycle after acceptance. Fetch output appears in the response cycle, and a filled line hits from the following cycle.
- fetch_vaddr_i may change during a miss. The fill still uses the latched tag.
- icache_req_idx_o and tlb_req_vpn_o follow fetch_vaddr_i combinationally. Fetch holds vaddr stable while REQ is pending.

## Test plan
- **Reset, then single fetch:** fetch 0x1000, 2 cycles REQ, ready, resp 1 cycle later with line {D3,D2,D1,D0} → fetch_valid_o with D0 in the resp cycle. Then vaddr 0x100C → D3 hit at 0 latency, no request.
- **Misaligned:** vaddr 0x1002 → fetch_ex_valid_o=1, cause=1, origin=0x1002, icache_req_valid_o stays 0.
- **Replacement with NUM_LINES=2:** fill lines 0x1000, 0x2000, 0x3000 → 0x3000 replaces entry 0 (rr=0→1). Then 0x1000 misses and 0x2000 hits.
- **TLB:** resp with tlb_resp_miss_i → no fill, REQ re-asserted next cycle. Resp with tlb_resp_xcpt_i → fetch_valid_o=1, cause=2, buffer unchanged.
- **Flush in WAIT:** kill pulse for exactly 1 cycle. A stale resp 3 cycles later is discarded with fetch_valid_o=0. The next fetch 0x1000 misses.
- **Flush coincident with resp_valid in WAIT:** no fill, fetch_valid_o=0, state IDLE. Also assert rst_i during REQ → outputs 0 asynchronously.
